// File: rtl/aes_key_expand_128.sv
// AES-128 key schedule: emits round keys 0..NUM_ROUNDS, one per rk_valid/rk_ready handshake; key 0 one cycle after accept.
// Optional AES_KEY_REPLAY_EN adds an 11-key store and a replay_req input that re-emits the last completed schedule.
module aes_key_expand_128 #(
  parameter int DATA_W     = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid_in,
  input  logic [DATA_W-1:0] key_in,
  output logic              key_ready,
`ifdef AES_KEY_REPLAY_EN
  input  logic              replay_req,
`endif
  input  logic              rk_ready,
  output logic              rk_valid,
  output logic [DATA_W-1:0] round_key,
  output logic [3:0]        rk_idx,
  output logic              done
);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  // Forward S-box, row-major from entry 0x00; entry b lives at index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  state_t            state_q, state_d;
  logic              key_ready_q, key_ready_d;
  logic              rk_valid_q, rk_valid_d;
  logic [DATA_W-1:0] round_key_q, round_key_d;
  logic [3:0]        rk_idx_q, rk_idx_d;
  logic              done_q, done_d;
  logic [7:0]        rcon_q, rcon_d;

`ifdef AES_KEY_REPLAY_EN
  logic [DATA_W-1:0] store_q [0:NUM_ROUNDS];
  logic [DATA_W-1:0] store_d [0:NUM_ROUNDS];
  logic              store_vld_q, store_vld_d;
  logic              replay_q, replay_d;
`endif

  logic [31:0]       w0, w1, w2, w3, t_word, n0, n1, n2, n3;
  logic [DATA_W-1:0] next_key;

  always_comb begin
    w0       = round_key_q[127:96];
    w1       = round_key_q[95:64];
    w2       = round_key_q[63:32];
    w3       = round_key_q[31:0];
    t_word   = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h000000};
    n0       = w0 ^ t_word;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_comb begin
    state_d     = state_q;
    rk_valid_d  = rk_valid_q;
    round_key_d = round_key_q;
    rk_idx_d    = rk_idx_q;
    rcon_d      = rcon_q;
    done_d      = 1'b0;
`ifdef AES_KEY_REPLAY_EN
    store_d     = store_q;
    store_vld_d = store_vld_q;
    replay_d    = replay_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (key_valid_in && key_ready_q) begin
          round_key_d = key_in;
          rk_idx_d    = 4'd0;
          rcon_d      = 8'h01;
          rk_valid_d  = 1'b1;
          state_d     = EMIT;
`ifdef AES_KEY_REPLAY_EN
          replay_d    = 1'b0;
          store_vld_d = 1'b0;
        end else if (replay_req && key_ready_q && store_vld_q) begin
          round_key_d = store_q[0];
          rk_idx_d    = 4'd0;
          rk_valid_d  = 1'b1;
          state_d     = EMIT;
          replay_d    = 1'b1;
`endif
        end
      end
      EMIT: begin
        if (rk_valid_q && rk_ready) begin
`ifdef AES_KEY_REPLAY_EN
          store_d[rk_idx_q] = round_key_q;
`endif
          if (rk_idx_q == LAST_IDX) begin
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = DONE;
`ifdef AES_KEY_REPLAY_EN
            store_vld_d = 1'b1;
`endif
          end else begin
`ifdef AES_KEY_REPLAY_EN
            round_key_d = replay_q ? store_q[rk_idx_q + 4'd1] : next_key;
`else
            round_key_d = next_key;
`endif
            rk_idx_d = rk_idx_q + 4'd1;
            rcon_d   = xtime(rcon_q);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    key_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      round_key_q <= '0;
      rk_idx_q    <= 4'd0;
      done_q      <= 1'b0;
      rcon_q      <= 8'h01;
`ifdef AES_KEY_REPLAY_EN
      store_vld_q <= 1'b0;
      replay_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      rk_valid_q  <= rk_valid_d;
      round_key_q <= round_key_d;
      rk_idx_q    <= rk_idx_d;
      done_q      <= done_d;
      rcon_q      <= rcon_d;
`ifdef AES_KEY_REPLAY_EN
      store_q     <= store_d;
      store_vld_q <= store_vld_d;
      replay_q    <= replay_d;
`endif
    end
  end

  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign round_key = round_key_q;
  assign rk_idx    = rk_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Directed bench for aes_key_expand_128: scoreboard of expected round keys checked with immediate assertions.
module tb_aes_key_expand_128;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] A1_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_valid_in = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ready;
  logic         rk_ready = 1'b0;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   rk_idx;
  logic         done;
`ifdef AES_KEY_REPLAY_EN
  logic         replay_req = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_key_expand_128 dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid_in (key_valid_in),
    .key_in       (key_in),
    .key_ready    (key_ready),
`ifdef AES_KEY_REPLAY_EN
    .replay_req   (replay_req),
`endif
    .rk_ready     (rk_ready),
    .rk_valid     (rk_valid),
    .round_key    (round_key),
    .rk_idx       (rk_idx),
    .done         (done)
  );

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         has_key;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  bit           done_due = 1'b0;
  bit           rep_ok = 1'b0;
  logic [127:0] cur_key = '0;
  logic [127:0] rep_key = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected schedule for a key; intermediate keys of KEY_C1 are checked by index only.
  task automatic push_key(input logic [127:0] k);
    for (int i = 0; i <= 10; i++) begin
      exp_t e;
      e.idx     = 4'(i);
      e.key     = '0;
      e.has_key = 1'b0;
      if (k == KEY_A1) begin
        e.key = A1_RK[i];
        e.has_key = 1'b1;
      end else if (i == 0) begin
        e.key = k;
        e.has_key = 1'b1;
      end else if (k == KEY_C1 && i == 1) begin
        e.key = C1_RK1;
        e.has_key = 1'b1;
      end else if (k == KEY_C1 && i == 10) begin
        e.key = C1_RK10;
        e.has_key = 1'b1;
      end
      sb.push_back(e);
    end
    cur_key = k;
  endtask

  // One cycle: check outputs at negedge, then drive inputs for the next posedge and predict it.
  task automatic tick(input logic rst, input logic kv, input logic [127:0] k,
                      input logic rdy, input logic rep);
    bit   exp_rdy;
    exp_t e;
    @(negedge clk);
    exp_rdy = (sb.size() == 0) && !done_due;
    chk("key_ready", 128'(key_ready), 128'(exp_rdy));
    chk("rk_valid", 128'(rk_valid), 128'(sb.size() != 0));
    chk("done", 128'(done), 128'(done_due));
    if (sb.size() != 0) begin
      chk("rk_idx", 128'(rk_idx), 128'(sb[0].idx));
      if (sb[0].has_key) chk("round_key", round_key, sb[0].key);
    end
    done_due = 1'b0;
    reset = rst;
    key_valid_in = kv;
    key_in = k;
    rk_ready = rdy;
`ifdef AES_KEY_REPLAY_EN
    replay_req = rep;
`endif
    if (rst) begin
      sb.delete();
      rep_ok = 1'b0;
    end else begin
      if (sb.size() != 0 && rdy) begin
        e = sb.pop_front();
        if (e.idx == 4'd10) begin
          done_due = 1'b1;
          rep_key = cur_key;
          rep_ok = 1'b1;
        end
      end
      if (exp_rdy && kv) begin
        rep_ok = 1'b0;
        push_key(k);
      end
`ifdef AES_KEY_REPLAY_EN
      else if (exp_rdy && rep && rep_ok) push_key(rep_key);
`else
      else if (rep) $display("replay request ignored without replay support");
`endif
    end
  endtask

  task automatic drain(input logic kv, input logic [127:0] k);
    int n = 0;
    while ((sb.size() != 0 || done_due) && n < 60) begin
      tick(1'b0, kv, k, 1'b1, 1'b0);
      n++;
    end
    chk("drain_bound", 128'(n < 60), 128'(1));
  endtask

  initial begin
    // Reset state
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("reset_round_key", round_key, 128'h0);
    chk("reset_rk_idx", 128'(rk_idx), 128'h0);

    // FIPS-197 A.1 at full rate
    tick(1'b0, 1'b1, KEY_A1, 1'b1, 1'b0);
    drain(1'b0, '0);

    // Backpressure: stall three cycles while key 4 is presented
    tick(1'b0, 1'b1, KEY_A1, 1'b1, 1'b0);
    repeat (4) tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    drain(1'b0, '0);

    // New key held from rk_idx=5: ignored until after the done cycle
    tick(1'b0, 1'b1, KEY_A1, 1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    drain(1'b1, KEY_C1);
    tick(1'b0, 1'b1, KEY_C1, 1'b1, 1'b0);

    // Back-to-back: A.1 presented at key_ready rise, rcon must restart
    drain(1'b1, KEY_A1);
    tick(1'b0, 1'b1, KEY_A1, 1'b1, 1'b0);
    drain(1'b0, '0);

    // Reset while rk_idx=7 is presented
    tick(1'b0, 1'b1, KEY_C1, 1'b1, 1'b0);
    repeat (7) tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("midreset_rk_idx", 128'(rk_idx), 128'h0);
    chk("midreset_round_key", round_key, 128'h0);

`ifdef AES_KEY_REPLAY_EN
    // Replay with an empty store produces nothing
    repeat (3) tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
`endif

    tick(1'b0, 1'b1, KEY_A1, 1'b1, 1'b0);
    drain(1'b0, '0);

`ifdef AES_KEY_REPLAY_EN
    tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
    drain(1'b0, '0);
`endif

    tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
